gray_conv_arbiter: RTL and testbench

GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

---
 rtl/gray_conv_pkg.sv | 17 +
 rtl/bin2gray.sv | 12 +
 rtl/gray_conv_arbiter.sv | 119 +++++++++++
 tb/tb_gray_conv_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_conv_pkg.sv
// Shared types and constants for the Gray-converting round-robin arbiter.
package gray_conv_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_NREQ  = 4;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Width of a requester index; at least one bit even for tiny NREQ.
    function automatic int unsigned calc_idw(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary to reflected-Gray converter.
module bin2gray #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray_c
);

    // Each Gray bit is the XOR of adjacent binary bits; MSB passes through.
    assign gray_c = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding a single bin2gray converter and a one-entry
// output register. Optional out_parity port: define GRAY_CONV_ARBITER_PARITY_EN.
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned NREQ  = DEF_NREQ,
    localparam int unsigned IDW   = calc_idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_gray,
    output logic [IDW-1:0]        out_id
`ifdef GRAY_CONV_ARBITER_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    state_t            state_q;
    state_t            state_d;
    logic [IDW-1:0]    rr_ptr;
    logic [NREQ-1:0]   grant_c;
    logic [IDW-1:0]    grant_id_c;
    logic              found_c;
    logic              accept_c;
    logic              in_xfer_c;
    logic [WIDTH-1:0]  sel_data_c;
    logic [WIDTH-1:0]  gray_c;

    // Search from rr_ptr upward (modulo NREQ) for the first valid requester.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        grant_c    = '0;
        grant_id_c = '0;
        found_c    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(rr_ptr) + i) % NREQ;
            if (!found_c && req_valid[idx]) begin
                found_c    = 1'b1;
                grant_id_c = IDW'(idx);
            end
        end
        if (found_c) begin
            grant_c[grant_id_c] = 1'b1;
        end
    end

    // Output slot can take a new operand when empty or draining this cycle.
    assign accept_c   = (!out_valid || out_ready) && !rst;
    assign req_ready  = grant_c & {NREQ{accept_c}};
    assign in_xfer_c  = |req_ready;
    assign sel_data_c = req_data[32'(grant_id_c)*WIDTH +: WIDTH];
    assign out_valid  = (state_q == FULL);

    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin    (sel_data_c),
        .gray_c (gray_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fill on input transfer, drain on out_ready without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (in_xfer_c) state_d = FULL;
            FULL:    if (out_ready && !in_xfer_c) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Round-robin pointer moves past the requester that just transferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (in_xfer_c) begin
            rr_ptr <= (32'(grant_id_c) == NREQ - 1) ? '0 : grant_id_c + IDW'(1);
        end
    end

    // Result register captures the converted operand on every input transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_gray <= '0;
            out_id   <= '0;
        end else if (in_xfer_c) begin
            out_gray <= gray_c;
            out_id   <= grant_id_c;
        end
    end

`ifdef GRAY_CONV_ARBITER_PARITY_EN
    // Parity of the Gray result, registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_parity <= 1'b0;
        end else if (in_xfer_c) begin
            out_parity <= ^gray_c;
        end
    end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: a driver predicts grants and queues
// expected results; an independent monitor pops and compares them.
module tb_gray_conv_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = 2;

    typedef struct {
        logic [WIDTH-1:0] gray;
        int unsigned      id;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_gray;
    logic [IDW-1:0]        out_id;
`ifdef GRAY_CONV_ARBITER_PARITY_EN
    logic                  out_parity;
`endif

    gray_conv_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_id    (out_id)
`ifdef GRAY_CONV_ARBITER_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    exp_t        sb_q[$];
    int unsigned m_ptr  = 0;
    bit          m_full = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive at negedge, then predict and check grants.
    task automatic drive_cycle(input logic [NREQ-1:0] v, input logic [WIDTH-1:0] d [NREQ],
                               input logic rdy, input logic r);
        logic [NREQ-1:0] exp_rdy;
        int              k;
        exp_t            e;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        out_ready = rdy;
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = d[i];
        #1;
        if (r) begin
            m_full = 1'b0;
            m_ptr  = 0;
            sb_q.delete();
        end
        chk("out_valid", 64'(out_valid), 64'(m_full));
        exp_rdy = '0;
        k       = -1;
        if (!r && (!m_full || rdy)) begin
            for (int i = 0; i < NREQ; i++) begin
                if (k < 0 && v[(m_ptr + i) % NREQ]) k = int'((m_ptr + i) % NREQ);
            end
        end
        if (k >= 0) begin
            exp_rdy[k] = 1'b1;
            e.gray = d[k] ^ (d[k] >> 1);
            e.id   = k;
            sb_q.push_back(e);
            m_ptr  = (k + 1) % NREQ;
            m_full = 1'b1;
        end else if (rdy || r) begin
            m_full = 1'b0;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    endtask

    // Monitor: compare the presented result against the queue head each cycle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_empty: out_valid with no expected result at %0t", $time);
                end else begin
                    chk("out_gray", 64'(out_gray), 64'(sb_q[0].gray));
                    chk("out_id", 64'(out_id), 64'(sb_q[0].id));
`ifdef GRAY_CONV_ARBITER_PARITY_EN
                    chk("out_parity", 64'(out_parity), 64'(^sb_q[0].gray));
`endif
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    logic [WIDTH-1:0] dz [NREQ];
    logic [WIDTH-1:0] dd [NREQ];
    logic [WIDTH-1:0] held_gray;
    logic [IDW-1:0]   held_id;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            dz[i] = '0;
            dd[i] = 32'h1000_0000 * (i + 1) + 32'h0000_0011;
        end
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;

        // Reset values
        #5;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_gray", 64'(out_gray), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        drive_cycle(4'b1111, dd, 1'b1, 1'b1);
        chk("rst_req_ready", 64'(req_ready), 64'd0);

        // Single request on req0
        dd[0] = 32'h0000_0005;
        drive_cycle(4'b0001, dd, 1'b1, 1'b0);
        drive_cycle(4'b0000, dd, 1'b1, 1'b0);
        chk("single_gray", 64'(out_gray), 64'h0000_0007);
        chk("single_id", 64'(out_id), 64'd0);

        // Boundary values on req2
        dd[2] = 32'hFFFF_FFFF;
        drive_cycle(4'b0100, dd, 1'b1, 1'b0);
        drive_cycle(4'b0000, dd, 1'b1, 1'b0);
        chk("ones_gray", 64'(out_gray), 64'h8000_0000);
        chk("ones_id", 64'(out_id), 64'd2);
        dd[2] = 32'h0000_0000;
        drive_cycle(4'b0100, dd, 1'b1, 1'b0);
        drive_cycle(4'b0000, dd, 1'b1, 1'b0);
        chk("zero_gray", 64'(out_gray), 64'h0000_0000);

`ifdef GRAY_CONV_ARBITER_PARITY_EN
        dd[1] = 32'h0000_0003;
        drive_cycle(4'b0010, dd, 1'b1, 1'b0);
        drive_cycle(4'b0000, dd, 1'b1, 1'b0);
        chk("par_gray", 64'(out_gray), 64'h0000_0002);
        chk("par_bit", 64'(out_parity), 64'd1);
`endif

        // Fairness: all requesters valid, sink always ready
        for (int c = 0; c < 8; c++) drive_cycle(4'b1111, dd, 1'b1, 1'b0);

        // Backpressure: hold output for three cycles while full
        drive_cycle(4'b1111, dd, 1'b0, 1'b0);
        held_gray = out_gray;
        held_id   = out_id;
        for (int c = 0; c < 3; c++) begin
            drive_cycle(4'b1111, dd, 1'b0, 1'b0);
            chk("bp_gray", 64'(out_gray), 64'(held_gray));
            chk("bp_id", 64'(out_id), 64'(held_id));
        end
        for (int c = 0; c < 4; c++) drive_cycle(4'b1111, dd, 1'b1, 1'b0);

        // Reset mid-stream, then lowest valid requester wins first
        drive_cycle(4'b1111, dd, 1'b1, 1'b1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        drive_cycle(4'b1111, dd, 1'b1, 1'b1);
        drive_cycle(4'b1100, dd, 1'b1, 1'b0);
        drive_cycle(4'b0000, dd, 1'b1, 1'b0);
        chk("midrst_first_id", 64'(out_id), 64'd2);

        // Randomized traffic
        for (int c = 0; c < 10000; c++) begin
            logic [NREQ-1:0] v;
            for (int i = 0; i < NREQ; i++) dd[i] = $urandom;
            v = NREQ'($urandom);
            drive_cycle(v, dd, ($urandom_range(0, 3) != 0), 1'b0);
        end

        // Drain and confirm nothing is left outstanding
        for (int c = 0; c < 3; c++) drive_cycle(4'b0000, dz, 1'b1, 1'b0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
